// File: rtl/pcie_wr_combiner.sv
// Combines dword writes into qword writes for a byte-enabled RAM.
// Holds one partial qword and emits it when full, displaced, flushed or idle too long.
module pcie_wr_combiner #(
   parameter int ADDR_NBITS = 5,
   parameter int TIMEOUT    = 16
) (
   input  logic                  clk_in,
   input  logic                  reset_in,
   input  logic                  dwValid_in,
   output logic                  dwReady_out,
   input  logic [ADDR_NBITS:0]   dwAddr_in,
   input  logic [31:0]           dwData_in,
   input  logic [3:0]            dwByteEn_in,
   input  logic                  flush_in,
   output logic                  writeEnable_out,
   output logic [7:0]            spanEnables_out,
   output logic [ADDR_NBITS-1:0] writeAddr_out,
   output logic [63:0]           writeData_out,
   output logic                  busy_out
);

   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

   logic                  hold_valid_r, hold_valid_s;
   logic [ADDR_NBITS-1:0] hold_addr_r, hold_addr_s;
   logic [63:0]           hold_data_r, hold_data_s;
   logic [7:0]            hold_be_r, hold_be_s;
   logic [7:0]            timer_r, timer_s;
   logic                  pend_r, pend_s;
   logic                  ready_r;
   logic                  we_r;
   logic [7:0]            span_r;
   logic [ADDR_NBITS-1:0] waddr_r;
   logic [63:0]           wdata_r;

   logic                  accept_s, discard_s, take_s, same_s;
   logic [ADDR_NBITS-1:0] new_addr_s;
   logic [7:0]            new_be_s, merge_be_s;
   logic [63:0]           new_data_s, merge_data_s;
   logic                  emit_s;
   logic [ADDR_NBITS-1:0] emit_addr_s;
   logic [63:0]           emit_data_s;
   logic [7:0]            emit_be_s;

   // Lane placement of the offered dword and byte-wise merge with the hold
   always_comb begin
      accept_s   = dwValid_in & ready_r;
      discard_s  = accept_s & (dwByteEn_in == 4'h0);
      take_s     = accept_s & ~discard_s;
      new_addr_s = dwAddr_in[ADDR_NBITS:1];
      same_s     = hold_valid_r & (hold_addr_r == new_addr_s);
      if (dwAddr_in[0]) begin
         new_be_s   = {dwByteEn_in, 4'h0};
         new_data_s = {dwData_in, 32'h0};
      end else begin
         new_be_s   = {4'h0, dwByteEn_in};
         new_data_s = {32'h0, dwData_in};
      end
      merge_be_s = hold_be_r | new_be_s;
      for (int i = 0; i < 8; i++) begin
         merge_data_s[8*i +: 8] = new_be_s[i] ? new_data_s[8*i +: 8] : hold_data_r[8*i +: 8];
      end
   end

   // Hold/timer next state and emission decision
   always_comb begin
      hold_valid_s = hold_valid_r;
      hold_addr_s  = hold_addr_r;
      hold_data_s  = hold_data_r;
      hold_be_s    = hold_be_r;
      timer_s      = timer_r;
      pend_s       = 1'b0;
      emit_s       = 1'b0;
      emit_addr_s  = hold_addr_r;
      emit_data_s  = hold_data_r;
      emit_be_s    = hold_be_r;
      if (pend_r) begin
         // ready is low here, so no dword can arrive alongside the deferred emit
         emit_s       = 1'b1;
         hold_valid_s = 1'b0;
         timer_s      = 8'h00;
      end else if (take_s) begin
         timer_s = 8'h00;
         if (same_s) begin
            if ((merge_be_s == 8'hFF) || flush_in) begin
               emit_s       = 1'b1;
               emit_data_s  = merge_data_s;
               emit_be_s    = merge_be_s;
               hold_valid_s = 1'b0;
            end else begin
               hold_data_s = merge_data_s;
               hold_be_s   = merge_be_s;
            end
         end else begin
            hold_addr_s  = new_addr_s;
            hold_data_s  = new_data_s;
            hold_be_s    = new_be_s;
            if (hold_valid_r) begin
               emit_s       = 1'b1;
               hold_valid_s = 1'b1;
               pend_s       = flush_in;
            end else begin
               emit_s       = flush_in;
               emit_addr_s  = new_addr_s;
               emit_data_s  = new_data_s;
               emit_be_s    = new_be_s;
               hold_valid_s = ~flush_in;
            end
         end
      end else if (hold_valid_r) begin
         if (flush_in || (!discard_s && (timer_r == TIMEOUT_LAST))) begin
            emit_s       = 1'b1;
            hold_valid_s = 1'b0;
            timer_s      = 8'h00;
         end else if (discard_s) begin
            timer_s = timer_r;
         end else begin
            timer_s = timer_r + 8'h01;
         end
      end else begin
         timer_s = 8'h00;
      end
   end

   // State and registered write port
   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         hold_valid_r <= 1'b0;
         hold_addr_r  <= '0;
         hold_data_r  <= 64'h0;
         hold_be_r    <= 8'h00;
         timer_r      <= 8'h00;
         pend_r       <= 1'b0;
         ready_r      <= 1'b0;
         we_r         <= 1'b0;
         span_r       <= 8'h00;
         waddr_r      <= '0;
         wdata_r      <= 64'h0;
      end else begin
         hold_valid_r <= hold_valid_s;
         hold_addr_r  <= hold_addr_s;
         hold_data_r  <= hold_data_s;
         hold_be_r    <= hold_be_s;
         timer_r      <= timer_s;
         pend_r       <= pend_s;
         ready_r      <= ~pend_s;
         we_r         <= emit_s;
         span_r       <= emit_s ? emit_be_s : 8'h00;
         if (emit_s) begin
            waddr_r <= emit_addr_s;
            wdata_r <= emit_data_s;
         end else begin
            waddr_r <= waddr_r;
            wdata_r <= wdata_r;
         end
      end
   end

   assign dwReady_out     = ready_r;
   assign writeEnable_out = we_r;
   assign spanEnables_out = span_r;
   assign writeAddr_out   = waddr_r;
   assign writeData_out   = wdata_r;
   assign busy_out        = hold_valid_r | pend_r;

endmodule

// File: tb/tb_pcie_wr_combiner.sv
// Directed bench for pcie_wr_combiner with hand-computed expectations.
module tb_pcie_wr_combiner;

   logic        clk_in = 1'b0;
   logic        reset_in;
   logic        dwValid_in;
   logic        dwReady_out;
   logic [5:0]  dwAddr_in;
   logic [31:0] dwData_in;
   logic [3:0]  dwByteEn_in;
   logic        flush_in;
   logic        writeEnable_out;
   logic [7:0]  spanEnables_out;
   logic [4:0]  writeAddr_out;
   logic [63:0] writeData_out;
   logic        busy_out;

   int checks   = 0;
   int failures = 0;
   int strobes  = 0;

   pcie_wr_combiner #(.ADDR_NBITS(5), .TIMEOUT(16)) dut (
      .clk_in(clk_in), .reset_in(reset_in),
      .dwValid_in(dwValid_in), .dwReady_out(dwReady_out),
      .dwAddr_in(dwAddr_in), .dwData_in(dwData_in), .dwByteEn_in(dwByteEn_in),
      .flush_in(flush_in), .writeEnable_out(writeEnable_out),
      .spanEnables_out(spanEnables_out), .writeAddr_out(writeAddr_out),
      .writeData_out(writeData_out), .busy_out(busy_out)
   );

   always #5 clk_in = ~clk_in;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of inputs, then sample 1 time unit after the edge
   task automatic cyc(input logic v, input logic [5:0] a, input logic [31:0] d,
                      input logic [3:0] be, input logic fl);
      dwValid_in  = v;
      dwAddr_in   = a;
      dwData_in   = d;
      dwByteEn_in = be;
      flush_in    = fl;
      @(posedge clk_in);
      #1;
   endtask

   initial begin
      reset_in = 1'b1;
      dwValid_in = 1'b0; dwAddr_in = 6'd0; dwData_in = 32'h0; dwByteEn_in = 4'h0; flush_in = 1'b0;
      repeat (3) @(posedge clk_in);
      #1;
      chk("rst_we",    64'(writeEnable_out), 64'd0);
      chk("rst_span",  64'(spanEnables_out), 64'd0);
      chk("rst_addr",  64'(writeAddr_out),   64'd0);
      chk("rst_data",  writeData_out,        64'd0);
      chk("rst_ready", 64'(dwReady_out),     64'd0);
      chk("rst_busy",  64'(busy_out),        64'd0);
      #2 reset_in = 1'b0;
      #1 chk("ready_before_edge", 64'(dwReady_out), 64'd0);
      cyc(1'b0, 6'd0, 32'h0, 4'h0, 1'b0);
      chk("ready_after_edge", 64'(dwReady_out), 64'd1);

      // Two halves of qword 3 combine into one full strobe
      cyc(1'b1, 6'd6, 32'h11223344, 4'hF, 1'b0);
      chk("full_first_we",   64'(writeEnable_out), 64'd0);
      chk("full_first_busy", 64'(busy_out),        64'd1);
      cyc(1'b1, 6'd7, 32'h55667788, 4'hF, 1'b0);
      chk("full_we",   64'(writeEnable_out), 64'd1);
      chk("full_addr", 64'(writeAddr_out),   64'd3);
      chk("full_data", writeData_out,        64'h5566778811223344);
      chk("full_span", 64'(spanEnables_out), 64'hFF);
      chk("full_busy", 64'(busy_out),        64'd0);
      cyc(1'b0, 6'd0, 32'h0, 4'h0, 1'b0);
      chk("after_we",   64'(writeEnable_out), 64'd0);
      chk("after_span", 64'(spanEnables_out), 64'd0);
      chk("after_addr", 64'(writeAddr_out),   64'd3);
      chk("after_data", writeData_out,        64'h5566778811223344);

      // Different qword address displaces the partial hold
      cyc(1'b1, 6'd2, 32'hAABBCCDD, 4'h3, 1'b0);
      chk("disp_first_we", 64'(writeEnable_out), 64'd0);
      cyc(1'b1, 6'd4, 32'h01020304, 4'hF, 1'b0);
      chk("disp_we",   64'(writeEnable_out), 64'd1);
      chk("disp_addr", 64'(writeAddr_out),   64'd1);
      chk("disp_span", 64'(spanEnables_out), 64'h03);
      chk("disp_data", 64'(writeData_out[15:0]), 64'hCCDD);
      chk("disp_busy", 64'(busy_out),        64'd1);
      cyc(1'b0, 6'd0, 32'h0, 4'h0, 1'b1);
      chk("flush_we",   64'(writeEnable_out), 64'd1);
      chk("flush_addr", 64'(writeAddr_out),   64'd2);
      chk("flush_span", 64'(spanEnables_out), 64'h0F);
      chk("flush_data", 64'(writeData_out[31:0]), 64'h01020304);
      chk("flush_busy", 64'(busy_out),        64'd0);

      // Idle timeout forces out a partial qword after exactly 16 idle cycles
      cyc(1'b1, 6'd9, 32'h5A5A5AEE, 4'h1, 1'b0);
      chk("to_load_busy", 64'(busy_out), 64'd1);
      for (int i = 1; i <= 15; i++) begin
         cyc(1'b0, 6'd0, 32'h0, 4'h0, 1'b0);
         chk("to_idle_we", 64'(writeEnable_out), 64'd0);
      end
      chk("to_idle15_busy", 64'(busy_out), 64'd1);
      cyc(1'b0, 6'd0, 32'h0, 4'h0, 1'b0);
      chk("to_we",   64'(writeEnable_out), 64'd1);
      chk("to_addr", 64'(writeAddr_out),   64'd4);
      chk("to_span", 64'(spanEnables_out), 64'h10);
      chk("to_data", 64'(writeData_out[39:32]), 64'hEE);
      chk("to_busy", 64'(busy_out),        64'd0);

      // Flush together with a displacing dword: two back-to-back strobes
      cyc(1'b1, 6'd0, 32'hCAFEF00D, 4'hF, 1'b0);
      cyc(1'b1, 6'd2, 32'h0BADBEEF, 4'hF, 1'b1);
      chk("fp_we",    64'(writeEnable_out), 64'd1);
      chk("fp_addr",  64'(writeAddr_out),   64'd0);
      chk("fp_span",  64'(spanEnables_out), 64'h0F);
      chk("fp_data",  64'(writeData_out[31:0]), 64'hCAFEF00D);
      chk("fp_ready", 64'(dwReady_out),     64'd0);
      chk("fp_busy",  64'(busy_out),        64'd1);
      cyc(1'b1, 6'd10, 32'h99999999, 4'hF, 1'b0);
      chk("fp2_we",    64'(writeEnable_out), 64'd1);
      chk("fp2_addr",  64'(writeAddr_out),   64'd1);
      chk("fp2_span",  64'(spanEnables_out), 64'h0F);
      chk("fp2_data",  64'(writeData_out[31:0]), 64'h0BADBEEF);
      chk("fp2_ready", 64'(dwReady_out),     64'd1);
      chk("fp2_busy",  64'(busy_out),        64'd0);

      // Same-address merge keeps newest byte per lane
      cyc(1'b1, 6'd1, 32'h11111111, 4'h2, 1'b0);
      cyc(1'b1, 6'd1, 32'h22222222, 4'h4, 1'b0);
      chk("merge_we", 64'(writeEnable_out), 64'd0);
      cyc(1'b0, 6'd0, 32'h0, 4'h0, 1'b1);
      chk("merge_strobe", 64'(writeEnable_out), 64'd1);
      chk("merge_addr",   64'(writeAddr_out),   64'd0);
      chk("merge_span",   64'(spanEnables_out), 64'h60);
      chk("merge_data",   64'(writeData_out[55:40]), 64'h2211);
      cyc(1'b0, 6'd0, 32'h0, 4'h0, 1'b0);
      chk("merge_single", 64'(writeEnable_out), 64'd0);

      // Asynchronous reset discards a held qword
      cyc(1'b1, 6'd3, 32'hDEADBEEF, 4'hF, 1'b0);
      dwValid_in = 1'b0;
      chk("ar_busy_pre", 64'(busy_out), 64'd1);
      #2 reset_in = 1'b1;
      #1;
      chk("ar_ready", 64'(dwReady_out),     64'd0);
      chk("ar_busy",  64'(busy_out),        64'd0);
      chk("ar_data",  writeData_out,        64'd0);
      chk("ar_span",  64'(spanEnables_out), 64'd0);
      @(posedge clk_in);
      #2 reset_in = 1'b0;
      for (int i = 0; i < 20; i++) begin
         cyc(1'b0, 6'd0, 32'h0, 4'h0, 1'b0);
         if (writeEnable_out) strobes++;
      end
      chk("ar_no_strobe", 64'(strobes), 64'd0);
      cyc(1'b1, 6'd5, 32'h12345678, 4'h0, 1'b0);
      chk("be0_we",   64'(writeEnable_out), 64'd0);
      chk("be0_busy", 64'(busy_out),        64'd0);
      cyc(1'b0, 6'd0, 32'h0, 4'h0, 1'b0);
      chk("be0_busy2", 64'(busy_out),       64'd0);
      chk("be0_we2",   64'(writeEnable_out), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pcie_wr_combiner.md
PCIE_WR_COMBINER -- requirements
Module: pcie_wr_combiner

Interface
REQ-001 Parameter ADDR_NBITS, default 5: qword address width, matching the downstream byte-enabled RAM.
REQ-002 Parameter TIMEOUT, default 16, range 2..255: idle cycles before a partial qword is forced out.
REQ-003 clk_in  input  1  sole clock; all state changes on its rising edge.
REQ-004 reset_in  input  1  asynchronous, active-high reset.
REQ-005 dwValid_in  input  1  a dword write is offered this cycle.
REQ-006 dwReady_out  output  1  block accepts the offered dword this cycle.
REQ-007 dwAddr_in  input  ADDR_NBITS+1  dword address; bit 0 selects the upper (1) or lower (0) half of the qword.
REQ-008 dwData_in  input  32  dword write data, byte 0 in bits 7:0.
REQ-009 dwByteEn_in  input  4  per-byte enables for dwData_in.
REQ-010 flush_in  input  1  forces out any held partial qword.
REQ-011 writeEnable_out  output  1  one-cycle qword write strobe to the RAM.
REQ-012 spanEnables_out  output  8  qword byte enables.
REQ-013 writeAddr_out  output  ADDR_NBITS  qword address.
REQ-014 writeData_out  output  64  qword data.
REQ-015 busy_out  output  1  held qword or pending flush exists.

Function
REQ-016 Accept SHALL occur on a rising edge where dwValid_in and dwReady_out are both high.
REQ-017 dwReady_out SHALL be high except during reset and the single FLUSH_PEND cycle (REQ-025).
REQ-018 Lane mapping: an accepted dword SHALL occupy qword bytes 3:0 (addr bit 0 = 0) or 7:4 (addr bit 0 = 1), with its byte enables in the same lanes.
REQ-019 An accepted dword with dwByteEn_in = 0 SHALL be discarded with no state change, including the idle timer.
REQ-020 Hold empty + accept: the dword SHALL load into the hold register; no output.
REQ-021 Hold valid + accept with the same qword address (dwAddr_in[ADDR_NBITS:1]): enabled new bytes SHALL overwrite held bytes and enables SHALL be OR-ed.
REQ-022 If the merged enables equal 8'hFF, the merged qword SHALL be emitted on that edge and the hold SHALL become empty.
REQ-023 Hold valid + accept with a different qword address: the held qword SHALL be emitted on that edge and the new dword SHALL load into the hold.
REQ-024 Idle timer: cleared on every accept; increments each cycle the hold is valid with no accept; on the edge ending the TIMEOUT-th consecutive idle cycle the hold SHALL be emitted and emptied.
REQ-025 flush_in with no accept: the hold, if valid, SHALL be emitted and emptied; with an empty hold it SHALL have no effect.
REQ-026 flush_in with accept: cases REQ-020/021 SHALL emit the merged qword at once; case REQ-023 SHALL emit the old qword, enter FLUSH_PEND (ready low one cycle) and emit the new dword on the next edge.
REQ-027 Emission SHALL be registered: writeEnable_out high for exactly one cycle, with spanEnables_out/writeAddr_out/writeData_out valid that cycle; at most one emission per cycle.
REQ-028 spanEnables_out SHALL be 0 and data/address SHALL hold their last values when writeEnable_out is low.
REQ-029 Byte lanes never written in an emitted qword SHALL have enable 0; their data value is don't-care.
REQ-030 busy_out SHALL equal hold-valid OR FLUSH_PEND.

Reset
REQ-031 While reset_in is high: writeEnable_out=0, spanEnables_out=0, writeAddr_out=0, writeData_out=0, dwReady_out=0, busy_out=0; hold empty, timer 0, FLUSH_PEND clear.
REQ-032 Reset mid-operation SHALL discard held data without emitting it.
REQ-033 dwReady_out SHALL rise on the first clock edge after reset_in falls.

Verification
REQ-034 Accept addr 6 data 0x11223344 BE F, then addr 7 data 0x55667788 BE F -> one strobe at addr 3, data 0x5566778811223344, enables FF, the cycle after the second accept.
REQ-035 Accept addr 2 BE 3, then addr 4 BE F -> strobe at addr 1, enables 03; hold now addr 2 lower, enables 0F, busy_out=1.
REQ-036 Accept addr 9 BE 1, idle TIMEOUT=16 cycles -> strobe at addr 4, enables 10, exactly after the 16th idle cycle; busy_out falls the same edge.
REQ-037 Hold addr 0 BE F, accept addr 2 BE F with flush_in -> strobe addr 0 enables 0F, dwReady_out low one cycle, strobe addr 1 enables 0F next cycle.
REQ-038 Accept addr 1 BE 2 then addr 1 BE 4 data differing, then flush -> single strobe enables 60, later dword's byte 2 and earlier dword's byte 1 present.
REQ-039 Hold valid, assert reset_in asynchronously mid-cycle -> all outputs zero immediately, no strobe after release; BE=0 dword afterwards -> no strobe, busy_out stays 0.
